// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest counter the clamp helper supports; callers zero-extend and truncate.
  localparam int unsigned CLAMP_W = 64;

  function automatic logic [CLAMP_W-1:0] load_clamp(input logic [CLAMP_W-1:0] val,
                                                    input logic [CLAMP_W-1:0] lim);
    load_clamp = (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/updown_counter_next.sv
// Next-count and terminal-event computation for updown_counter_n (combinational).
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] max_val,
  input  logic             updown,
  input  logic             sat,
  output logic [WIDTH-1:0] next_q,
  output logic             term
);

  always_comb begin
    next_q = Q;
    term   = 1'b0;
    if (updown == DIR_UP) begin
      if (Q >= max_val) begin
        next_q = (sat == MODE_SAT) ? max_val : '0;
        term   = 1'b1;
      end else begin
        next_q = Q + 1'b1;
      end
    end else begin
      // An over-range count (max_val lowered at runtime) snaps to the limit silently.
      if (Q > max_val) begin
        next_q = max_val;
      end else if (Q == '0) begin
        next_q = (sat == MODE_SAT) ? '0 : max_val;
        term   = 1'b1;
      end else begin
        next_q = Q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with programmable terminal value, load, wrap/saturate.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             updown,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] Q,
  output logic             C,
  output logic             at_max,
  output logic             at_zero
);

  logic [WIDTH-1:0] next_q;
  logic             term;
  logic [WIDTH-1:0] clamped;

  updown_counter_next #(.WIDTH(WIDTH)) u_next (
    .Q       (Q),
    .max_val (max_val),
    .updown  (updown),
    .sat     (sat),
    .next_q  (next_q),
    .term    (term)
  );

  assign clamped = WIDTH'(load_clamp(CLAMP_W'(load_val), CLAMP_W'(max_val)));

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      Q <= '0;
      C <= 1'b0;
    end else if (load) begin
      Q <= clamped;
      C <= 1'b0;
    end else if (en) begin
      Q <= next_q;
      C <= term;
    end else begin
      C <= 1'b0;
    end
  end

  assign at_max  = (Q >= max_val);
  assign at_zero = (Q == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed vector bench for updown_counter_n (WIDTH=8).
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       clr_n, en, updown, sat, load;
  logic [7:0] load_val, max_val;
  logic [7:0] Q;
  logic       C, at_max, at_zero;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  updown_counter_n #(.WIDTH(8)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .updown   (updown),
    .sat      (sat),
    .load     (load),
    .load_val (load_val),
    .max_val  (max_val),
    .Q        (Q),
    .C        (C),
    .at_max   (at_max),
    .at_zero  (at_zero)
  );

  typedef struct {
    string      name;
    logic       clr_n, load, en, updown, sat;
    logic [7:0] load_val, max_val;
    logic [7:0] exp_q;
    logic       exp_c;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic r, logic ld, logic e, logic ud, logic s,
                              logic [7:0] lv, logic [7:0] mv, logic [7:0] eq, logic ec);
    vec_t v;
    v.name = nm; v.clr_n = r; v.load = ld; v.en = e; v.updown = ud; v.sat = s;
    v.load_val = lv; v.max_val = mv; v.exp_q = eq; v.exp_c = ec;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic apply(vec_t v);
    clr_n = v.clr_n; load = v.load; en = v.en; updown = v.updown; sat = v.sat;
    load_val = v.load_val; max_val = v.max_val;
    @(posedge clk);
    #1;
    check({v.name, ".Q"}, 32'(Q), 32'(v.exp_q));
    check({v.name, ".C"}, 32'(C), 32'(v.exp_c));
    check({v.name, ".at_max"}, 32'(at_max), 32'(v.exp_q >= v.max_val));
    check({v.name, ".at_zero"}, 32'(at_zero), 32'(v.exp_q == 8'd0));
  endtask

  initial begin
    clr_n = 1'b0; load = 1'b0; en = 1'b0; updown = 1'b1; sat = 1'b0;
    load_val = '0; max_val = 8'd255;

    //          name      clr ld en ud sat lv   mv   Q    C
    vecs.push_back(mk("reset",   0, 0, 0, 1, 0,   0, 255,   0, 0));
    // wrap up through 255
    vecs.push_back(mk("w_ld",    1, 1, 0, 1, 0, 254, 255, 254, 0));
    vecs.push_back(mk("w_up1",   1, 0, 1, 1, 0,   0, 255, 255, 0));
    vecs.push_back(mk("w_up2",   1, 0, 1, 1, 0,   0, 255,   0, 1));
    vecs.push_back(mk("w_up3",   1, 0, 1, 1, 0,   0, 255,   1, 0));
    // wrap down from 0 with max 9
    vecs.push_back(mk("d_ld",    1, 1, 0, 0, 0,   0,   9,   0, 0));
    vecs.push_back(mk("d_dn1",   1, 0, 1, 0, 0,   0,   9,   9, 1));
    vecs.push_back(mk("d_dn2",   1, 0, 1, 0, 0,   0,   9,   8, 0));
    // saturate up at 5
    vecs.push_back(mk("s_ld",    1, 1, 0, 1, 1,   0,   5,   0, 0));
    for (int unsigned i = 1; i <= 10; i++)
      vecs.push_back(mk($sformatf("s_up%0d", i), 1, 0, 1, 1, 1, 0, 5,
                        (i < 5) ? 8'(i) : 8'd5, (i > 5) ? 1'b1 : 1'b0));
    vecs.push_back(mk("s_hold",  1, 0, 0, 1, 1,   0,   5,   5, 0));
    // load clamp beats en
    vecs.push_back(mk("l_clamp", 1, 1, 1, 1, 0, 200, 100, 100, 0));
    vecs.push_back(mk("l_dn",    1, 0, 1, 0, 0,   0, 100,  99, 0));
    // max lowered under the count
    vecs.push_back(mk("m_ld1",   1, 1, 0, 0, 0,   7,  10,   7, 0));
    vecs.push_back(mk("m_dn",    1, 0, 1, 0, 0,   0,   3,   3, 0));
    vecs.push_back(mk("m_ld2",   1, 1, 0, 1, 0,   7,  10,   7, 0));
    vecs.push_back(mk("m_up",    1, 0, 1, 1, 0,   0,   3,   0, 1));
    vecs.push_back(mk("m_ld3",   1, 1, 0, 1, 1,   7,  10,   7, 0));
    vecs.push_back(mk("m_upsat", 1, 0, 1, 1, 1,   0,   3,   3, 1));
    // saturate down at 0
    vecs.push_back(mk("z_ld",    1, 1, 0, 0, 1,   0,   9,   0, 0));
    vecs.push_back(mk("z_dn1",   1, 0, 1, 0, 1,   0,   9,   0, 1));
    vecs.push_back(mk("z_dn2",   1, 0, 1, 0, 1,   0,   9,   0, 1));
    vecs.push_back(mk("z_hold",  1, 0, 0, 0, 1,   0,   9,   0, 0));
    // max_val = 0
    vecs.push_back(mk("m0_up",   1, 0, 1, 1, 0,   0,   0,   0, 1));
    vecs.push_back(mk("m0_dn",   1, 0, 1, 0, 0,   0,   0,   0, 1));
    vecs.push_back(mk("m0_rst",  0, 0, 1, 1, 0,   0,   0,   0, 0));
    // plain hold
    vecs.push_back(mk("h_ld",    1, 1, 0, 1, 0,  50, 100,  50, 0));
    vecs.push_back(mk("h_hold",  1, 0, 0, 1, 0,  50, 100,  50, 0));
    // reset overrides load and en
    vecs.push_back(mk("r_ld",    1, 1, 0, 1, 0,  40, 100,  40, 0));
    vecs.push_back(mk("r_all",   0, 1, 1, 1, 0,  60, 100,   0, 0));
    vecs.push_back(mk("r_up",    1, 0, 1, 1, 0,   0, 100,   1, 0));
    vecs.push_back(mk("r_up2",   1, 0, 1, 1, 0,   0, 100,   2, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // at_max/at_zero follow max_val with no clock edge in between
    clr_n = 1'b1; load = 1'b1; en = 1'b0; load_val = 8'd5; max_val = 8'd20;
    @(posedge clk); #1;
    load = 1'b0;
    check("comb.Q", 32'(Q), 32'd5);
    max_val = 8'd5; #1;
    check("comb.at_max_eq", 32'(at_max), 32'd1);
    max_val = 8'd6; #1;
    check("comb.at_max_below", 32'(at_max), 32'd0);
    max_val = 8'd4; #1;
    check("comb.at_max_above", 32'(at_max), 32'd1);
    check("comb.at_zero", 32'(at_zero), 32'd0);
    // one down count from over-range snaps to 4 and clears C
    en = 1'b1; updown = 1'b0; sat = 1'b0;
    @(posedge clk); #1;
    check("comb.snap_q", 32'(Q), 32'd4);
    check("comb.snap_c", 32'(C), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
